// File: rtl/pri_arbiter8_if.sv
// Handshake bundle for pri_arbiter8: active-low enable/requests in, registered grant status out.
interface pri_arbiter8_if;
    logic       EI;
    logic [7:0] REQ_N;
    logic [7:0] GNT_N;
    logic [2:0] A;
    logic       GS;
    logic       EO;
    logic       TIMEOUT;

    modport master (output EI, REQ_N, input GNT_N, A, GS, EO, TIMEOUT);
    modport slave  (input EI, REQ_N, output GNT_N, A, GS, EO, TIMEOUT);
endinterface

// File: rtl/pri_arbiter8.sv
// pri_arbiter8: 8-way active-low arbiter with bounded hold time and a dead cycle between owners.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise fixed priority with line 7 highest.
module pri_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic          CLK,
    input  logic          RST,
    pri_arbiter8_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] gnt_n_q, gnt_n_d;
    logic [2:0] a_q, a_d;
    logic       gs_q, gs_d;
    logic       eo_q, eo_d;
    logic       timeout_q, timeout_d;
    logic [2:0] winner;

`ifdef ARB_ROUND_ROBIN_EN
    logic [2:0] last_q, last_d;

    // Scan from the farthest distance inward so the nearest requester below 'last' wins.
    function automatic logic [2:0] pick(input logic [7:0] req, input logic [2:0] last);
        logic [2:0] w;
        logic [2:0] idx;
        w = last;
        for (int k = 8; k >= 1; k--) begin
            idx = last - 3'(k);
            if (req[idx]) w = idx;
        end
        return w;
    endfunction

    assign winner = pick(~bus.REQ_N, last_q);
`else
    function automatic logic [2:0] pick(input logic [7:0] req);
        logic [2:0] w;
        w = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) w = 3'(i);
        end
        return w;
    endfunction

    assign winner = pick(~bus.REQ_N);
`endif

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        a_d       = a_q;
        timeout_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.EI && bus.REQ_N != 8'hFF) begin
                    state_d = GRANT;
                    a_d     = winner;
                    hold_d  = 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = winner;
`endif
                end
            end
            GRANT: begin
                // Disable outranks release, which outranks the hold limit.
                if (bus.EI) begin
                    state_d = IDLE;
                end else if (bus.REQ_N[a_q]) begin
                    state_d = RELEASE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        gs_d    = (state_d != GRANT);
        gnt_n_d = (state_d == GRANT) ? ~(8'h01 << a_d) : 8'hFF;
        eo_d    = !(!bus.EI && state_d == IDLE && bus.REQ_N == 8'hFF);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            hold_q    <= 8'd0;
            gnt_n_q   <= 8'hFF;
            a_q       <= 3'd0;
            gs_q      <= 1'b1;
            eo_q      <= 1'b1;
            timeout_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= 3'd0;
`endif
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            gnt_n_q   <= gnt_n_d;
            a_q       <= a_d;
            gs_q      <= gs_d;
            eo_q      <= eo_d;
            timeout_q <= timeout_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

    assign bus.GNT_N   = gnt_n_q;
    assign bus.A       = a_q;
    assign bus.GS      = gs_q;
    assign bus.EO      = eo_q;
    assign bus.TIMEOUT = timeout_q;
endmodule

// File: tb/tb_pri_arbiter8.sv
// Self-checking bench for pri_arbiter8: directed scenarios plus randomized traffic against
// an owner/hold-count reference model.
module tb_pri_arbiter8;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pri_arbiter8_if bus();
    pri_arbiter8 #(.MAX_HOLD(MH)) dut (.CLK(clk), .RST(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    // Reference: who owns the bus (-1 = nobody), how many cycles it has shown as granted,
    // and whether we are in the dead cycle after a release.
    int m_owner, m_held, m_last;
    bit m_dead, m_to, m_eo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] req_n, input int last);
`ifdef ARB_ROUND_ROBIN_EN
        for (int d = 1; d <= 8; d++)
            if (!req_n[(last - d + 16) % 8]) return (last - d + 16) % 8;
`else
        for (int i = 7; i >= 0; i--)
            if (!req_n[i]) return i;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_last = 0;
        m_dead = 0; m_to = 0; m_eo = 1;
    endtask

    task automatic model_edge(input logic ei, input logic [7:0] req_n);
        m_to = 0;
        if (m_dead) begin
            m_dead = 0;
        end else if (m_owner < 0) begin
            if (!ei && req_n != 8'hFF) begin
                m_owner = pick(req_n, m_last);
                m_last  = m_owner;
                m_held  = 1;
            end
        end else if (ei) begin
            m_owner = -1;
        end else if (req_n[m_owner]) begin
            m_owner = -1; m_dead = 1;
        end else if (m_held == MH) begin
            m_owner = -1; m_dead = 1; m_to = 1;
        end else begin
            m_held++;
        end
        m_eo = !(!ei && m_owner < 0 && !m_dead && req_n == 8'hFF);
    endtask

    task automatic compare_all(input string tag);
        logic [7:0] e_gnt;
        e_gnt = (m_owner < 0) ? 8'hFF : ~(8'h01 << m_owner);
        chk({tag, "_gnt_n"}, bus.GNT_N, e_gnt);
        chk({tag, "_gs"}, bus.GS, (m_owner < 0));
        chk({tag, "_eo"}, bus.EO, m_eo);
        chk({tag, "_timeout"}, bus.TIMEOUT, m_to);
        if (m_owner >= 0) chk({tag, "_a"}, bus.A, m_owner);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge(bus.EI, bus.REQ_N);
        #1;
        compare_all(tag);
    endtask

    // Called at posedge+1: asserts reset between edges and checks outputs before the next edge.
    task automatic async_reset(input string tag);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all(tag);
        chk({tag, "_a0"}, bus.A, 0);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int exp_order[$];
        int n_seen;
        logic [7:0] r;

        rst = 1'b1; bus.EI = 1'b1; bus.REQ_N = 8'hFF;
        model_reset();
        #1;
        compare_all("rst_async");
        chk("rst_a", bus.A, 0);
        repeat (2) @(posedge clk);
        #1;
        compare_all("rst_hold");
        rst = 1'b0;
        step("idle_dis");

        bus.EI = 1'b0; bus.REQ_N = 8'b1010_1111;
        step("pri");
        chk("pri_gnt_exact", bus.GNT_N, 8'b1011_1111);
        chk("pri_a_exact", bus.A, 6);
        chk("pri_gs_exact", bus.GS, 0);
        chk("pri_eo_exact", bus.EO, 1);

        bus.REQ_N = 8'b1110_1111;
        step("rel_dead");
        chk("rel_dead_gs", bus.GS, 1);
        step("rel_idle");
        step("rel_g4");
        chk("rel_g4_a", bus.A, 4);
        chk("rel_g4_gs", bus.GS, 0);

        bus.REQ_N = 8'hFF;
        step("drop_rel");
        step("drop_idle");
        chk("idle_eo_low", bus.EO, 0);
        chk("idle_gs_high", bus.GS, 1);

        bus.REQ_N = 8'b1111_1011;
        step("to_grant");
        for (int i = 0; i < MH - 1; i++) begin
            step("to_hold");
            chk("to_hold_gs", bus.GS, 0);
        end
        step("to_fire");
        chk("to_fire_pulse", bus.TIMEOUT, 1);
        chk("to_fire_gs", bus.GS, 1);
        step("to_idle");
        chk("to_idle_pulse", bus.TIMEOUT, 0);
        step("to_regrant");
        chk("to_regrant_a", bus.A, 2);
        chk("to_regrant_gs", bus.GS, 0);

        bus.EI = 1'b1;
        step("dis");
        chk("dis_gnt", bus.GNT_N, 8'hFF);
        chk("dis_timeout", bus.TIMEOUT, 0);
        bus.EI = 1'b0;
        step("reen");
        chk("reen_gs", bus.GS, 0);

        async_reset("rst_mid");
        step("post_rst");
        chk("post_rst_a", bus.A, 2);

        async_reset("rst_rr");
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{7, 3, 7, 3};
`else
        exp_order = '{7, 7, 7};
`endif
        n_seen = 0;
        for (int c = 0; c < 60 && n_seen < exp_order.size(); c++) begin
            int prev;
            r = 8'b0111_0111;
            if (m_owner >= 0 && m_held >= 2) r[m_owner] = 1'b1;
            bus.REQ_N = r;
            prev = m_owner;
            step("rr");
            if (prev < 0 && m_owner >= 0) begin
                chk("rr_order", bus.A, exp_order[n_seen]);
                n_seen++;
            end
        end
        chk("rr_count", n_seen, exp_order.size());

        bus.REQ_N = 8'hFF;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 4) == 0) bus.REQ_N = 8'hFF;
                else bus.REQ_N = 8'($urandom) | 8'($urandom);
            end
            if (m_owner >= 0 && $urandom_range(0, 3) == 0) begin
                r = bus.REQ_N;
                r[m_owner] = 1'b1;
                bus.REQ_N = r;
            end
            bus.EI = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pri_arbiter8.md
PRI_ARBITER8 -- requirements
Module: pri_arbiter8

Interface
REQ-001 The block SHALL have a parameter MAX_HOLD, default 16, giving the maximum number of cycles a grant may be held (legal range 2..255).
REQ-002 CLK  input  1  The single clock; all state SHALL change on its rising edge.
REQ-003 RST  input  1  Reset; asynchronous and active-high.
REQ-004 EI  input  1  Enable, active-low; 1 SHALL disable arbitration.
REQ-005 REQ_N  input  8  Request lines, active-low, one per requester 0..7.
REQ-006 GNT_N  output  8  Grant lines, active-low, one-hot or all-high, registered.
REQ-007 A  output  3  Binary index of the current grantee, registered; valid only while GS=0.
REQ-008 GS  output  1  Grant valid, active-low, registered.
REQ-009 EO  output  1  Enable-out, active-low, registered; 0 when the block is enabled, idle and no request is pending.
REQ-010 TIMEOUT  output  1  One-cycle high pulse, registered, flagging a forced release.

Function
REQ-011 The block SHALL implement three states: IDLE, GRANT and RELEASE.
- IDLE: no grant; GNT_N=8'hFF, GS=1.
- At an edge with EI=0 and REQ_N!=8'hFF: select a winner per REQ-014, enter GRANT, drive GNT_N[w]=0, A=w, GS=0, and clear the hold counter.
- Latency: request at edge N SHALL be granted on the outputs after edge N.
REQ-012 GRANT SHALL advance as follows, checking the conditions in this order at each edge:
- EI=1: go to IDLE immediately, with no RELEASE and no TIMEOUT.
- REQ_N[A]=1 (requester released): go to RELEASE.
- Hold counter = MAX_HOLD-1 while REQ_N[A]=0: pulse TIMEOUT=1 for one cycle and go to RELEASE.
- Otherwise: increment the hold counter (8-bit, never wraps because of the MAX_HOLD limit) and stay in GRANT.
REQ-013 RELEASE SHALL last exactly one cycle with GNT_N=8'hFF and GS=1, then go to IDLE; this is the dead cycle between owners. A request present during RELEASE is arbitrated in the following IDLE cycle.
REQ-014 Winner selection SHALL be fixed priority, with index 7 highest and index 0 lowest, unless REQ-021 applies.
REQ-015 EO SHALL be registered as 0 when EI=0, the next state is IDLE and REQ_N=8'hFF; it SHALL be 1 otherwise.
REQ-016 Requests that change during GRANT SHALL NOT change the grantee; only the grantee's own line is monitored.
REQ-017 A timed-out requester that keeps REQ_N low SHALL be eligible again in the next IDLE cycle under normal selection.

Reset
REQ-018 While RST=1, regardless of CLK, the outputs SHALL be:
- GNT_N=8'hFF
- A=3'b000
- GS=1
- EO=1
- TIMEOUT=0
- state IDLE, hold counter 0, last-grantee register 0.
REQ-019 Reset asserted mid-GRANT SHALL drop the grant at once, with no RELEASE cycle and no TIMEOUT pulse.
REQ-020 After RST falls, the first arbitration SHALL occur at the first rising edge meeting the conditions of REQ-011.

Configuration
REQ-021 With macro ARB_ROUND_ROBIN_EN defined, selection SHALL be rotating.
- Search order: last-1, last-2, ... wrapping mod 8, ending at last, where last is the last-grantee register.
- The last-grantee register SHALL update on every entry to GRANT.
- Reset value last=0 gives a first search order of 7..0.
REQ-022 With ARB_ROUND_ROBIN_EN undefined, selection SHALL be fixed priority per REQ-014, and the last-grantee register SHALL be absent.

Verification
REQ-023 Priority: EI=0, REQ_N=8'b1010_1111 -> next cycle GNT_N=8'b1011_1111, A=6, GS=0, EO=1.
REQ-024 Release and dead cycle:
- Grantee 6 raises REQ_N[6] -> one RELEASE cycle with GS=1.
- REQ_N[4]=0 still pending -> grant 4 in the cycle after the IDLE arbitration.
REQ-025 Timeout: MAX_HOLD=4, single request on line 2 held low -> GS=0 for 4 cycles, TIMEOUT=1 on the 5th cycle with GS=1, then re-grant of 2.
REQ-026 Disable and idle:
- EI=1 during GRANT -> GNT_N=8'hFF next cycle, no TIMEOUT.
- EI=0 with REQ_N=8'hFF -> EO=0, GS=1.
REQ-027 Async reset: RST pulsed mid-GRANT between clock edges -> outputs at reset values immediately, before the next CLK edge.
REQ-028 Round robin (ARB_ROUND_ROBIN_EN defined): lines 7 and 3 low continuously, each releasing after 2 cycles -> grant order 7, 3, 7, 3; with the macro undefined -> 7, 7, 7.
